reaction_measure: RTL and testbench
===================================

REACTION_MEASURE -- requirements
Module: reaction_measure

Interface
REQ-001 Parameter TICKS_PER_MS, default 50000, clock1 cycles per millisecond; legal range 1 to 2^20.
REQ-002 clock1  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 key  input  1  reset, synchronous and active-high; also starts a new round.
REQ-004 go  input  1  level from the upstream random-delay stage; high = stimulus lamp on.
REQ-005 stop  input  1  player button, already synchronised and debounced to clock1, active-high.
REQ-006 time_bcd  output  16  measured reaction time in ms, four BCD digits: [15:12] thousands down to [3:0] units.
REQ-007 done  output  1  high = valid measurement held in time_bcd.
REQ-008 false_start  output  1  high = stop pressed before go.
REQ-009 timeout  output  1  high = no press within 9999 ms.

Function
REQ-010 The block SHALL implement the states WAIT, COUNT, DONE, FOUL and TMO.
REQ-011 Press event = stop high this cycle and stop_q low, where stop_q is stop registered one cycle.
REQ-012 WAIT: a press event SHALL move to FOUL; otherwise go high SHALL move to COUNT with the prescaler and time_bcd both zero.
REQ-013 WAIT with a press event and go high in the same cycle SHALL go to FOUL; false start has priority.
REQ-014 COUNT: the prescaler SHALL count 0 to TICKS_PER_MS-1 and wrap.
REQ-015 COUNT: each wrap is an ms tick, and each ms tick SHALL increment time_bcd by 1 in BCD.
REQ-016 BCD increment: a digit at 9 SHALL become 0 and carry into the next digit; no digit SHALL ever hold A-F.
REQ-017 COUNT: a press event SHALL move to DONE, and time_bcd SHALL keep its value from before that edge.
REQ-018 COUNT: an ms tick coinciding with a press event SHALL be suppressed.
REQ-019 COUNT: an ms tick with time_bcd at 9999 and no press event SHALL move to TMO, and time_bcd SHALL hold 9999.
REQ-020 COUNT: go falling SHALL be ignored; the measurement continues.
REQ-021 DONE, FOUL and TMO SHALL be absorbing until key; stop and go SHALL be ignored in these states.
REQ-022 Outputs SHALL be registered: done, false_start and timeout are high exactly when the state is DONE, FOUL or TMO respectively.
REQ-023 At most one of done, false_start and timeout SHALL be high in any cycle.
REQ-024 time_bcd SHALL read 0000 in FOUL.
REQ-025 Latency: the flags and the frozen time_bcd SHALL be visible on the first clock1 edge after the triggering cycle.
REQ-026 Reaction time resolution SHALL be 1 ms, truncated: a press within the first ms after go SHALL read 0000.

Reset
REQ-027 key high at a clock1 edge SHALL set state to WAIT, time_bcd to 0000, done/false_start/timeout to 0, and the prescaler to 0.
REQ-028 key high at a clock1 edge SHALL load stop_q with 1, so a button held through reset produces no press event.
REQ-029 key SHALL override every other input in the same cycle, including mid-COUNT.
REQ-030 key held high SHALL keep the block in WAIT with all outputs at reset values.
REQ-031 Power-up values are not required; the bench SHALL apply key before checking outputs.

Verification (TICKS_PER_MS=4)
REQ-032 Nominal: key pulse; go high; press at 4*237+2 cycles after COUNT entry -> time_bcd=0x0237, done=1 next cycle, other flags 0.
REQ-033 Carry chain: press just after the 1000th tick -> time_bcd=0x1000; every sampled digit in the run <=9.
REQ-034 False start: press while go=0, and separately a press in the same cycle go rises -> false_start=1, time_bcd=0x0000, done=0.
REQ-035 Timeout: go high, no press for 40000+ cycles -> timeout=1, time_bcd=0x9999; a later press leaves all outputs unchanged.
REQ-036 Reset mid-count and held button: key during COUNT -> next cycle WAIT with all outputs 0. Then stop held high through reset and after -> no FOUL. Then a fresh press before go -> FOUL.
REQ-037 Tick/press collision: press in the exact wrap cycle of the prescaler -> time_bcd equals the pre-tick value, and go dropping during COUNT has no effect.

Source files
------------

// File: rtl/reaction_measure.sv
// Reaction-time meter: counts whole milliseconds from the go lamp to the first
// button press and presents the result as four BCD digits with status flags.
module reaction_measure #(
  parameter int unsigned TICKS_PER_MS = 50000
) (
  input  logic        clock1,
  input  logic        key,
  input  logic        go,
  input  logic        stop,
  output logic [15:0] time_bcd,
  output logic        done,
  output logic        false_start,
  output logic        timeout
);

  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);
  localparam logic [15:0] TIME_MAX = 16'h9999;

  typedef enum logic [2:0] {
    S_WAIT,
    S_COUNT,
    S_DONE,
    S_FOUL,
    S_TMO
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_stop_q;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [15:0]   r_time;
  logic [15:0]   w_time_nxt;
  logic          r_done;
  logic          r_false_start;
  logic          r_timeout;
  logic          w_press;
  logic          w_wrap;

  assign w_press = stop & ~r_stop_q;
  assign w_wrap  = (r_presc == PRESC_MAX);

  // Four-digit BCD increment; a 9 rolls to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state, prescaler and time update; terminal states hold everything.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_time_nxt  = r_time;
    case (r_state)
      S_WAIT: begin
        if (w_press) begin
          w_state_nxt = S_FOUL;
          w_time_nxt  = '0;
        end else if (go) begin
          w_state_nxt = S_COUNT;
          w_presc_nxt = '0;
          w_time_nxt  = '0;
        end
      end
      S_COUNT: begin
        w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);
        if (w_press) begin
          w_state_nxt = S_DONE;
        end else if (w_wrap) begin
          if (r_time == TIME_MAX) begin
            w_state_nxt = S_TMO;
          end else begin
            w_time_nxt = bcd_inc(r_time);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State and output registers; key overrides all inputs.
  always_ff @(posedge clock1) begin
    if (key) begin
      r_state       <= S_WAIT;
      r_presc       <= '0;
      r_time        <= '0;
      r_stop_q      <= 1'b1;
      r_done        <= 1'b0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_presc       <= w_presc_nxt;
      r_time        <= w_time_nxt;
      r_stop_q      <= stop;
      r_done        <= (w_state_nxt == S_DONE);
      r_false_start <= (w_state_nxt == S_FOUL);
      r_timeout     <= (w_state_nxt == S_TMO);
    end
  end

  assign time_bcd    = r_time;
  assign done        = r_done;
  assign false_start = r_false_start;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_reaction_measure.sv
// Randomised scoreboard bench for reaction_measure: stimulus predicts each
// result event from whole-ms arithmetic, a negedge monitor checks what appears.
module tb_reaction_measure;

  localparam int unsigned TPM     = 4;
  localparam int unsigned TMO_CYC = TPM * 10000;

  logic        clock1 = 1'b0;
  logic        key;
  logic        go;
  logic        stop;
  logic [15:0] time_bcd;
  logic        done;
  logic        false_start;
  logic        timeout;

  reaction_measure #(.TICKS_PER_MS(TPM)) dut (
    .clock1      (clock1),
    .key         (key),
    .go          (go),
    .stop        (stop),
    .time_bcd    (time_bcd),
    .done        (done),
    .false_start (false_start),
    .timeout     (timeout)
  );

  always #5 clock1 = ~clock1;

  typedef struct {
    logic [2:0]  flags;
    logic [15:0] t;
    longint      cyc;
  } exp_t;

  localparam logic [2:0] F_DONE = 3'b100;
  localparam logic [2:0] F_FOUL = 3'b010;
  localparam logic [2:0] F_TMO  = 3'b001;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  logic        key_q;
  logic [2:0]  prev_flags = 3'b000;
  logic [15:0] held = 16'h0000;

  always @(posedge clock1) begin
    cyc   <= cyc + 1;
    key_q <= key;
  end

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each new result.
  always @(negedge clock1) begin : monitor
    logic [2:0] f;
    exp_t       e;
    f = {done, false_start, timeout};
    tests++;
    if ($countones(f) > 1) begin
      fails++;
      $display("FAIL onehot: flags=%b at cycle %0d", f, cyc);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (time_bcd[4*k +: 4] > 4'd9) begin
        fails++;
        $display("FAIL digit%0d: time_bcd=%h has non-decimal digit", k, time_bcd);
      end
    end
    if (key_q === 1'b1) begin
      tests++;
      if (f !== 3'b000 || time_bcd !== 16'h0000) begin
        fails++;
        $display("FAIL reset: flags=%b time=%h, want 000/0000", f, time_bcd);
      end
    end else if (f != 3'b000 && prev_flags == 3'b000) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: flags=%b time=%h at cycle %0d", f, time_bcd, cyc);
      end else begin
        e = sb.pop_front();
        if (f !== e.flags || time_bcd !== e.t || cyc != e.cyc) begin
          fails++;
          $display("FAIL event: got flags=%b time=%h cycle=%0d, want flags=%b time=%h cycle=%0d",
                   f, time_bcd, cyc, e.flags, e.t, e.cyc);
        end
      end
      held = time_bcd;
    end else if (prev_flags != 3'b000) begin
      tests++;
      if (f !== prev_flags || time_bcd !== held) begin
        fails++;
        $display("FAIL absorb: flags=%b time=%h, want flags=%b time=%h", f, time_bcd, prev_flags, held);
      end
    end
    prev_flags = f;
  end

  task automatic step();
    @(posedge clock1);
    #1;
  endtask

  task automatic push(input logic [2:0] f, input int ms);
    exp_t e;
    e.flags = f;
    e.t     = to_bcd(ms);
    e.cyc   = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic hold);
    key  = 1'b1;
    go   = 1'b0;
    stop = hold;
    step();
    key = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n = int'($urandom_range(0, 4));
    stop = 1'b0;
    go   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Random go/stop activity that a terminal state must ignore.
  task automatic absorb_noise();
    for (int i = 0; i < 6; i++) begin
      go   = 1'($urandom);
      stop = 1'($urandom);
      step();
    end
    stop = 1'b0;
    go   = 1'b0;
  endtask

  task automatic foul_round(input bit same_cycle);
    do_reset(1'b0);
    idle_wait();
    go   = same_cycle;
    stop = 1'b1;
    push(F_FOUL, 0);
    step();
    stop = 1'b0;
    absorb_noise();
  endtask

  // Press lands d edges after the edge that first sees go high.
  task automatic count_round(input int d, input int drop_at);
    do_reset(1'b0);
    idle_wait();
    go   = 1'b1;
    stop = 1'b0;
    step();
    for (int i = 1; i <= d; i++) begin
      if (drop_at != 0 && i >= drop_at) go = 1'b0;
      stop = (i == d);
      if (i == d && d <= int'(TMO_CYC)) push(F_DONE, (d - 1) / int'(TPM));
      if (i == int'(TMO_CYC) && d > int'(TMO_CYC)) push(F_TMO, 9999);
      step();
    end
    stop = 1'b0;
    absorb_noise();
  endtask

  task automatic held_button_round();
    do_reset(1'b1);
    stop = 1'b1;
    for (int i = 0; i < 6; i++) step();
    stop = 1'b0;
    step();
    stop = 1'b1;
    push(F_FOUL, 0);
    step();
    stop = 1'b0;
    absorb_noise();
  endtask

  task automatic mid_reset_round();
    do_reset(1'b0);
    go = 1'b1;
    step();
    for (int i = 0; i < 21; i++) step();
    key  = 1'b1;
    stop = 1'b1;
    step();
    key = 1'b0;
    go  = 1'b0;
    step();
    stop = 1'b0;
    step();
    stop = 1'b1;
    push(F_FOUL, 0);
    step();
    stop = 1'b0;
    absorb_noise();
  endtask

  initial begin
    key  = 1'b1;
    go   = 1'b0;
    stop = 1'b0;
    step();
    step();
    count_round(int'(TPM) * 237 + 2, 0);
    count_round(int'(TPM) * 1000 + 1, 0);
    foul_round(1'b0);
    foul_round(1'b1);
    count_round(int'(TPM) * 5, 3);
    count_round(1, 0);
    count_round(int'(TPM), 0);
    count_round(int'(TPM) + 1, 0);
    held_button_round();
    mid_reset_round();
    for (int r = 0; r < 12; r++) begin
      int d;
      d = int'($urandom_range(1, 300));
      if ($urandom_range(0, 3) == 0) foul_round(1'($urandom));
      else count_round(d, int'($urandom_range(0, d)));
    end
    count_round(int'(TMO_CYC) + 10, 0);
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_events: %0d expected results never appeared", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
